// File: rtl/synth_ctrl_pkg.sv
// Shared constants and types for the synth control-input blocks.
// Consumers: sustain_variable (optional hysteresis via SUSTAIN_HYST_EN).
package synth_ctrl_pkg;

    localparam int unsigned SUSTAIN_IN_W  = 10;
    localparam int unsigned SUSTAIN_OUT_W = 4;
    localparam int unsigned SUSTAIN_BAND  = 1 << (SUSTAIN_IN_W - SUSTAIN_OUT_W);

    typedef logic [SUSTAIN_OUT_W-1:0] sustain_code_t;

endpackage

// File: rtl/sustain_quantizer.sv
// Combinational band quantizer: maps the registered input and current level to the next level.
// Hysteresis margin is applied only when SUSTAIN_HYST_EN is defined.
module sustain_quantizer
    import synth_ctrl_pkg::*;
#(
    parameter int unsigned IN_W  = SUSTAIN_IN_W,
    parameter int unsigned OUT_W = SUSTAIN_OUT_W,
    parameter int unsigned HYST  = 8
) (
    input  logic [IN_W-1:0]  in_q,
    input  logic [OUT_W-1:0] level,
    output logic [OUT_W-1:0] next_level
);

    localparam int unsigned SHIFT = IN_W - OUT_W;

`ifdef SUSTAIN_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    // A zero margin makes both threshold tests always pass, so the
    // disabled build collapses to plain quantization.
    localparam int unsigned MARGIN = HYST_ON ? HYST : 0;

    logic [OUT_W-1:0] cand;
    logic [IN_W:0]    lvl_base;
    logic [IN_W:0]    up_thr;
    logic [IN_W:0]    in_ext;
    logic [IN_W:0]    in_hyst;

    assign cand = in_q[IN_W-1 -: OUT_W];

    always_comb begin
        lvl_base   = (IN_W+1)'(level) << SHIFT;
        up_thr     = lvl_base + (IN_W+1)'(1 << SHIFT) + (IN_W+1)'(MARGIN);
        in_ext     = (IN_W+1)'(in_q);
        in_hyst    = in_ext + (IN_W+1)'(MARGIN);
        next_level = level;
        if ((cand > level) && (in_ext >= up_thr)) begin
            next_level = cand;
        end else if ((cand < level) && (in_hyst < lvl_base)) begin
            next_level = cand;
        end
    end

endmodule

// File: rtl/sustain_variable.sv
// Sustain control: registers the user value, quantizes it to a sustain-time code, strobes on change.
// Optional input hysteresis enabled by defining SUSTAIN_HYST_EN.
module sustain_variable
    import synth_ctrl_pkg::*;
#(
    parameter int unsigned IN_W  = SUSTAIN_IN_W,
    parameter int unsigned OUT_W = SUSTAIN_OUT_W,
    parameter int unsigned HYST  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  user_input0,
    output logic [OUT_W-1:0] sustainTime,
    output logic             sustain_changed
);

    logic [IN_W-1:0]  in_q;
    logic [OUT_W-1:0] next_level;

    sustain_quantizer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .HYST  (HYST)
    ) u_quant (
        .in_q       (in_q),
        .level      (sustainTime),
        .next_level (next_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q            <= '0;
            sustainTime     <= '0;
            sustain_changed <= 1'b0;
        end else begin
            in_q            <= user_input0;
            sustainTime     <= next_level;
            sustain_changed <= (next_level != sustainTime);
        end
    end

endmodule

// File: tb/tb_sustain_variable.sv
// Directed self-checking bench for sustain_variable; expectations track SUSTAIN_HYST_EN.
module tb_sustain_variable;
    import synth_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [9:0]    user_input0;
    sustain_code_t sustainTime;
    logic          sustain_changed;

    int errors = 0;
    int checks = 0;
    sustain_code_t prev_code;

    sustain_variable #(
        .IN_W  (10),
        .OUT_W (4),
        .HYST  (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .user_input0     (user_input0),
        .sustainTime     (sustainTime),
        .sustain_changed (sustain_changed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply a value, hold it three cycles, verify 2-edge latency and single strobe.
    task automatic apply(input string tag, input logic [9:0] v, input sustain_code_t exp);
        logic ch_exp;
        ch_exp = (exp != prev_code);
        user_input0 = v;
        tick();
        check({tag, "_lat_code"}, 32'(sustainTime), 32'(prev_code));
        check({tag, "_lat_strobe"}, 32'(sustain_changed), 32'd0);
        tick();
        check({tag, "_code"}, 32'(sustainTime), 32'(exp));
        check({tag, "_strobe"}, 32'(sustain_changed), 32'(ch_exp));
        tick();
        check({tag, "_hold_code"}, 32'(sustainTime), 32'(exp));
        check({tag, "_hold_strobe"}, 32'(sustain_changed), 32'd0);
        prev_code = exp;
    endtask

    initial begin
        rst_n       = 1'b0;
        user_input0 = 10'd600;
        prev_code   = 4'd0;

        // Reset held two cycles
        tick();
        tick();
        check("rst_code", 32'(sustainTime), 32'd0);
        check("rst_strobe", 32'(sustain_changed), 32'd0);

        rst_n = 1'b1;
        tick();
        check("rel1_code", 32'(sustainTime), 32'd0);
        check("rel1_strobe", 32'(sustain_changed), 32'd0);
        tick();
        check("rel2_code", 32'(sustainTime), 32'd9);
        check("rel2_strobe", 32'(sustain_changed), 32'd1);
        tick();
        check("rel3_code", 32'(sustainTime), 32'd9);
        check("rel3_strobe", 32'(sustain_changed), 32'd0);
        prev_code = 4'd9;

        // Sweep
        apply("sw0",   10'd0,   4'd0);
        apply("sw300", 10'd300, 4'd4);
        apply("sw400", 10'd400, 4'd6);
        apply("sw500", 10'd500, 4'd7);
        apply("sw600", 10'd600, 4'd9);
        apply("sw600r", 10'd600, 4'd9);

        // Extremes and hysteresis walk
        apply("ex1023", 10'd1023, 4'd15);
        apply("ex63",   10'd63,   4'd0);
`ifdef SUSTAIN_HYST_EN
        apply("ex64",  10'd64, 4'd0);
        apply("hy70",  10'd70, 4'd0);
        apply("hy72",  10'd72, 4'd1);
        apply("hy60",  10'd60, 4'd1);
        apply("hy55",  10'd55, 4'd0);
`else
        apply("ex64",  10'd64, 4'd1);
        apply("hy70",  10'd70, 4'd1);
        apply("hy72",  10'd72, 4'd1);
        apply("hy60",  10'd60, 4'd0);
        apply("hy55",  10'd55, 4'd0);
`endif

        // Mid-operation reset
        apply("mid300", 10'd300, 4'd4);
        user_input0 = 10'd600;
        tick();
        check("mid_pre_code", 32'(sustainTime), 32'd4);
        rst_n = 1'b0;
        tick();
        check("mid_rst_code", 32'(sustainTime), 32'd0);
        check("mid_rst_strobe", 32'(sustain_changed), 32'd0);
        rst_n = 1'b1;
        tick();
        check("mid_rel1_code", 32'(sustainTime), 32'd0);
        check("mid_rel1_strobe", 32'(sustain_changed), 32'd0);
        tick();
        check("mid_rel2_code", 32'(sustainTime), 32'd9);
        check("mid_rel2_strobe", 32'(sustain_changed), 32'd1);

        // Input changing every cycle
        user_input0 = 10'd160;
        tick();
        user_input0 = 10'd224;
        tick();
        check("fast1_code", 32'(sustainTime), 32'd2);
        check("fast1_strobe", 32'(sustain_changed), 32'd1);
        user_input0 = 10'd288;
        tick();
        check("fast2_code", 32'(sustainTime), 32'd3);
        check("fast2_strobe", 32'(sustain_changed), 32'd1);
        tick();
        check("fast3_code", 32'(sustainTime), 32'd4);
        check("fast3_strobe", 32'(sustain_changed), 32'd1);
        tick();
        check("fast4_strobe", 32'(sustain_changed), 32'd0);

        // Constant input for 20 cycles
        user_input0 = 10'd600;
        tick();
        tick();
        check("const_settle", 32'(sustainTime), 32'd9);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("const_strobe", 32'(sustain_changed), 32'd0);
            check("const_code", 32'(sustainTime), 32'd9);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
